// File: rtl/ex_wbuf.sv
// Posted-write buffer between the core data port and the RIB bus master port.
// Optional store-to-load forwarding is built when WBUF_FWD_EN is defined.
module ex_wbuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_data_i,
  input  logic          core_req_i,
  input  logic          core_we_i,
  output logic [DW-1:0] core_data_o,
  output logic          core_hold_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_data_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  input  logic [DW-1:0] bus_data_i,
  input  logic          bus_gnt_i,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic buf_empty;
  logic buf_full;
  logic push;
  logic pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == FullCnt);
  // Full is judged on the registered count, so a same-cycle pop never lifts the hold.
  assign push      = core_req_i & core_we_i & ~buf_full;
  assign pop       = ~buf_empty & bus_gnt_i;
  assign empty_o   = buf_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= core_addr_i;
      data_mem[wr_ptr_q] <= core_data_i;
    end
  end

`ifdef WBUF_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the last match is the youngest entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem[fwd_idx] == core_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_data_o  = '0;
    core_data_o = '0;
    core_hold_o = 1'b0;
    if (rst) begin
      if (!buf_empty) begin
        bus_req_o  = 1'b1;
        bus_we_o   = 1'b1;
        bus_addr_o = addr_mem[rd_ptr_q];
        bus_data_o = data_mem[rd_ptr_q];
      end
      if (core_req_i) begin
        if (core_we_i) begin
          core_hold_o = buf_full;
        end else if (buf_empty) begin
          bus_req_o   = 1'b1;
          bus_addr_o  = core_addr_i;
          core_data_o = bus_data_i;
          core_hold_o = ~bus_gnt_i;
        end else if (fwd_hit) begin
          core_data_o = fwd_data;
        end else begin
          core_hold_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_wbuf.sv
// Self-checking bench for ex_wbuf: scenario tasks plus a bus-write scoreboard.
module tb_ex_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr_i;
  logic [31:0] core_data_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [31:0] core_data_o;
  logic        core_hold_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_data_i;
  logic        bus_gnt_i;
  logic        empty_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;
  int  errors = 0;
  int  checks = 0;

  ex_wbuf #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_addr_i (core_addr_i),
    .core_data_i (core_data_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_data_o (core_data_o),
    .core_hold_o (core_hold_o),
    .bus_addr_o  (bus_addr_o),
    .bus_data_o  (bus_data_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_data_i  (bus_data_i),
    .bus_gnt_i   (bus_gnt_i),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  // Every completed bus write must be the oldest outstanding accepted write.
  always @(negedge clk) begin
    if (rst && bus_req_o && bus_we_o && bus_gnt_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bus_write_unexpected: got addr=%h data=%h, expected no write",
                 bus_addr_o, bus_data_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({bus_addr_o, bus_data_o} !== {mon_exp.addr, mon_exp.data}) begin
          errors++;
          $display("FAIL bus_write_order: got addr=%h data=%h, expected addr=%h data=%h",
                   bus_addr_o, bus_data_o, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data);
    @(posedge clk);
    #1;
    core_req_i  = req;
    core_we_i   = we;
    core_addr_i = addr;
    core_data_i = data;
  endtask

  task automatic wait_drained(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (empty_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst         = 1'b0;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h2000_0000;
    core_data_i = 32'h0;
    bus_data_i  = 32'h5555_AAAA;
    bus_gnt_i   = 1'b1;
    #2;
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req_o);
    end
    checks++;
    if (core_hold_o !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %b expected 0", core_hold_o);
    end
    checks++;
    if (empty_o !== 1'b1) begin
      errors++; $display("FAIL reset_empty: got %b expected 1", empty_o);
    end
    checks++;
    if (core_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_core_data: got %h expected 0", core_data_o);
    end
    @(posedge clk);
    #1;
    rst        = 1'b1;
    core_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (empty_o !== 1'b1) begin
      errors++; $display("FAIL reset_release_empty: got %b expected 1", empty_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    bit ok;
    addrs[0] = 32'h1000_0000; addrs[1] = 32'h1000_0004; addrs[2] = 32'h1000_0008;
    datas[0] = 32'h11;        datas[1] = 32'h22;        datas[2] = 32'h33;
    bus_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, addrs[i], datas[i]);
      sb.push_back('{addr: addrs[i], data: datas[i]});
      @(negedge clk);
      checks++;
      if (core_hold_o !== 1'b0) begin
        errors++; $display("FAIL b2b_hold[%0d]: got %b expected 0", i, core_hold_o);
      end
      if (i == 0) begin
        checks++;
        if (bus_req_o !== 1'b0) begin
          errors++; $display("FAIL b2b_first_cycle_bus_req: got %b expected 0", bus_req_o);
        end
      end else begin
        checks++;
        if (bus_addr_o !== addrs[i-1] || bus_we_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_bus_timing[%0d]: got addr=%h we=%b expected addr=%h we=1",
                   i, bus_addr_o, bus_we_o, addrs[i-1]);
        end
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_addr_o !== addrs[2] || bus_req_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last_write: got addr=%h req=%b expected addr=%h req=1",
               bus_addr_o, bus_req_o, addrs[2]);
    end
    wait_drained(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain: empty=%b left=%0d expected 1 and 0", ok, sb.size());
    end
  endtask

  task automatic test_full;
    bit ok;
    logic exp_hold;
    bus_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h3000_0000 + 32'(4 * i), 32'hA0 + 32'(i));
      exp_hold = (i == 4);
      if (!exp_hold) sb.push_back('{addr: 32'h3000_0000 + 32'(4 * i), data: 32'hA0 + 32'(i)});
      @(negedge clk);
      checks++;
      if (core_hold_o !== exp_hold) begin
        errors++; $display("FAIL full_hold[%0d]: got %b expected %b", i, core_hold_o, exp_hold);
      end
    end
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (core_hold_o !== 1'b1) begin
      errors++; $display("FAIL full_hold_during_pop: got %b expected 1", core_hold_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (core_hold_o !== 1'b0) begin
      errors++; $display("FAIL full_accept_after_pop: got %b expected 0", core_hold_o);
    end
    sb.push_back('{addr: 32'h3000_0010, data: 32'hA4});
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_drained(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++; $display("FAIL full_drain: empty=%b left=%0d expected 1 and 0", ok, sb.size());
    end
  endtask

  task automatic test_read_after_write;
    bit ok;
    bus_gnt_i  = 1'b0;
    bus_data_i = 32'hCAFE_F00D;
    drive(1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    sb.push_back('{addr: 32'h1000_0004, data: 32'hDEAD_BEEF});
    drive(1'b1, 1'b0, 32'h1000_0004, 32'h0);
    @(negedge clk);
`ifdef WBUF_FWD_EN
    checks++;
    if (core_hold_o !== 1'b0 || core_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL raw_forward: got hold=%b data=%h expected hold=0 data=deadbeef",
               core_hold_o, core_data_o);
    end
    checks++;
    if (bus_we_o !== 1'b1 || bus_addr_o !== 32'h1000_0004) begin
      errors++;
      $display("FAIL raw_forward_drain: got we=%b addr=%h expected we=1 addr=10000004",
               bus_we_o, bus_addr_o);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus_gnt_i = 1'b1;
`else
    checks++;
    if (core_hold_o !== 1'b1 || bus_we_o !== 1'b1) begin
      errors++;
      $display("FAIL raw_hold: got hold=%b we=%b expected hold=1 we=1", core_hold_o, bus_we_o);
    end
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (core_hold_o !== 1'b1) begin
      errors++; $display("FAIL raw_hold_on_drain: got %b expected 1", core_hold_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (core_hold_o !== 1'b0 || bus_we_o !== 1'b0 || bus_addr_o !== 32'h1000_0004 ||
        core_data_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL raw_passthrough: got hold=%b we=%b addr=%h data=%h expected 0 0 10000004 cafef00d",
               core_hold_o, bus_we_o, bus_addr_o, core_data_o);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
`endif
    wait_drained(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++; $display("FAIL raw_drain: empty=%b left=%0d expected 1 and 0", ok, sb.size());
    end
  endtask

  task automatic test_read_empty;
    bus_gnt_i  = 1'b0;
    bus_data_i = 32'h1234_5678;
    drive(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    for (int c = 0; c < 2; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      checks++;
      if (core_hold_o !== 1'b1 || bus_req_o !== 1'b1 || bus_we_o !== 1'b0 ||
          bus_addr_o !== 32'h2000_0000) begin
        errors++;
        $display("FAIL rd_empty_wait[%0d]: got hold=%b req=%b we=%b addr=%h expected 1 1 0 20000000",
                 c, core_hold_o, bus_req_o, bus_we_o, bus_addr_o);
      end
    end
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (core_hold_o !== 1'b0 || core_data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_empty_data: got hold=%b data=%h expected hold=0 data=12345678",
               core_hold_o, core_data_o);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0 || core_hold_o !== 1'b0 || bus_addr_o !== 32'h0 ||
        bus_data_o !== 32'h0 || core_data_o !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs: got req=%b hold=%b addr=%h wdata=%h rdata=%h expected all 0",
               bus_req_o, core_hold_o, bus_addr_o, bus_data_o, core_data_o);
    end
  endtask

  task automatic test_reset_mid_drain;
    bus_gnt_i = 1'b0;
    drive(1'b1, 1'b1, 32'h4000_0000, 32'h77);
    drive(1'b1, 1'b1, 32'h4000_0004, 32'h88);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b1 || empty_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_pending: got req=%b empty=%b expected req=1 empty=0",
               bus_req_o, empty_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus_req_o !== 1'b0 || empty_o !== 1'b1 || bus_we_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_reset: got req=%b we=%b empty=%b expected 0 0 1",
               bus_req_o, bus_we_o, empty_o);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus_req_o !== 1'b0 || empty_o !== 1'b1) begin
        errors++;
        $display("FAIL mid_drain_after_release[%0d]: got req=%b empty=%b expected 0 1",
                 c, bus_req_o, empty_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_read_after_write();
    test_read_empty();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
